// File: rtl/video_timing_if.sv
// Pixel-coordinate and video-output bundle for the raster timing generator.
// master: timing generator side; slave: pixel source / video sink side.
interface video_timing_if #(
   parameter int unsigned X_WIDTH = 11,
   parameter int unsigned Y_WIDTH = 10
) ();

   logic [X_WIDTH-1:0] x;
   logic [Y_WIDTH-1:0] y;
   logic [7:0]         in_r;
   logic [7:0]         in_g;
   logic [7:0]         in_b;
   logic [7:0]         r;
   logic [7:0]         g;
   logic [7:0]         b;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic               frame_start;

   modport master (
      output x, y, r, g, b, hsync, vsync, de, frame_start,
      input  in_r, in_g, in_b
   );

   modport slave (
      input  x, y, r, g, b, hsync, vsync, de, frame_start,
      output in_r, in_g, in_b
   );

endinterface

// File: rtl/video_timing.sv
// Free-running raster timing generator: requests pixels by x/y, registers colour and syncs.
// Optional VIDEO_TIMING_BLANK_EN forces registered colour to black outside the active area.
module video_timing #(
   parameter int unsigned HOR_ACTIVE_PIXELS = 1280,
   parameter int unsigned HOR_FRONT_PORCH   = 110,
   parameter int unsigned HOR_SYNC_PULSE    = 40,
   parameter int unsigned HOR_BACK_PORCH    = 220,
   parameter int unsigned VER_ACTIVE_PIXELS = 720,
   parameter int unsigned VER_FRONT_PORCH   = 5,
   parameter int unsigned VER_SYNC_PULSE    = 5,
   parameter int unsigned VER_BACK_PORCH    = 20,
   parameter bit          HSYNC_POLARITY    = 1'b1,
   parameter bit          VSYNC_POLARITY    = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   video_timing_if.master vid
);

   localparam int unsigned H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE
                                     + HOR_BACK_PORCH;
   localparam int unsigned V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE
                                     + VER_BACK_PORCH;
   localparam int unsigned X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
   localparam int unsigned Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT      = HW'(HOR_ACTIVE_PIXELS);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
   localparam logic [HW-1:0] H_SYNC_END = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH
                                              + HOR_SYNC_PULSE);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(VER_ACTIVE_PIXELS);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
   localparam logic [VW-1:0] V_SYNC_END = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH
                                              + VER_SYNC_PULSE);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

   if (HOR_ACTIVE_PIXELS < 2 || VER_ACTIVE_PIXELS < 2) begin : g_bad_active
      $error("video_timing: active pixels/lines must be at least 2");
   end
   if (HOR_FRONT_PORCH < 1 || HOR_SYNC_PULSE < 1 || HOR_BACK_PORCH < 1 ||
       VER_FRONT_PORCH < 1 || VER_SYNC_PULSE < 1 || VER_BACK_PORCH < 1) begin : g_bad_blank
      $error("video_timing: porch and sync widths must be at least 1");
   end

   logic [HW-1:0] h_cnt_q;
   logic [VW-1:0] v_cnt_q;
   logic          h_act;
   logic          v_act;
   logic          active;
   logic          hs0;
   logic          vs0;
   logic          first_pix;
   logic          h_wrap;
   logic [7:0]    r_d, g_d, b_d;
   logic [7:0]    r_q, g_q, b_q;
   logic          hsync_q;
   logic          vsync_q;
   logic          de_q;
   logic          frame_start_q;

   always_comb begin
      h_act     = h_cnt_q < H_ACT;
      v_act     = v_cnt_q < V_ACT;
      active    = h_act && v_act;
      hs0       = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
      vs0       = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
      first_pix = (h_cnt_q == '0) && (v_cnt_q == '0);
      h_wrap    = h_cnt_q == H_LAST;
   end

   // Each axis clamps independently so the pixel source never sees an out-of-range coordinate.
   assign vid.x = h_act ? h_cnt_q[X_WIDTH-1:0] : '0;
   assign vid.y = v_act ? v_cnt_q[Y_WIDTH-1:0] : '0;

   always_comb begin
`ifdef VIDEO_TIMING_BLANK_EN
      r_d = active ? vid.in_r : 8'h00;
      g_d = active ? vid.in_g : 8'h00;
      b_d = active ? vid.in_b : 8'h00;
`else
      r_d = vid.in_r;
      g_d = vid.in_g;
      b_d = vid.in_b;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else if (h_wrap) begin
         h_cnt_q <= '0;
         v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
         h_cnt_q <= h_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         de_q          <= 1'b0;
         hsync_q       <= ~HSYNC_POLARITY;
         vsync_q       <= ~VSYNC_POLARITY;
         frame_start_q <= 1'b0;
      end else begin
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
         de_q          <= active;
         hsync_q       <= hs0 ? HSYNC_POLARITY : ~HSYNC_POLARITY;
         vsync_q       <= vs0 ? VSYNC_POLARITY : ~VSYNC_POLARITY;
         frame_start_q <= first_pix;
      end
   end

   assign vid.r           = r_q;
   assign vid.g           = g_q;
   assign vid.b           = b_q;
   assign vid.de          = de_q;
   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.frame_start = frame_start_q;

endmodule
